icache_fill_ctrl: RTL and testbench

Control and line-fill engine for the direct-mapped, 8-set, 32-byte-line instruction cache. It is the writer side of the cache's tag, valid and data arrays. It accepts fetch requests from the IF stage and compares the tag read from the arrays. On a miss it runs a 4-beat 64-bit burst from physical memory, assembles the 256-bit line and writes it into the arrays. It then returns the requested 32-bit word.

---
 rtl/icache_pkg.sv | 31 +++
 rtl/icache_line_buf.sv | 30 +++
 rtl/icache_fill_ctrl.sv | 87 ++++++++
 tb/tb_icache_fill_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared widths, address field slicers and FSM state type for the
// instruction-cache fill controller.
package icache_pkg;

  localparam int TAG_W  = 24;
  localparam int IDX_W  = 3;
  localparam int WORD_W = 3;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int NBEATS = LINE_W / BEAT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TAG   = 2'd1,
    FILL  = 2'd2,
    WRITE = 2'd3
  } fill_state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[31:8];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    return a[7:5];
  endfunction

  function automatic logic [WORD_W-1:0] addr_word(input logic [31:0] a);
    return a[4:2];
  endfunction

endpackage

// File: rtl/icache_line_buf.sv
// Beat counter and 4x64 assembly register for one cache-line burst.
module icache_line_buf
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              i_clear,
  input  logic              i_beat_vld,
  input  logic [BEAT_W-1:0] i_data,
  output logic [LINE_W-1:0] o_line,
  output logic              o_last
);

  logic [1:0]                         r_beat;
  logic [NBEATS-1:0][BEAT_W-1:0]      r_slot;

  // Slot 0 lands in line bits [63:0]; the counter wraps after the 4th beat.
  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_beat <= '0;
      r_slot <= '0;
    end else if (i_beat_vld) begin
      r_slot[r_beat] <= i_data;
      r_beat         <= r_beat + 2'd1;
    end
  end

  assign o_line = r_slot;
  assign o_last = (r_beat == 2'd3);

endmodule

// File: rtl/icache_fill_ctrl.sv
// Fetch/compare FSM and line-fill engine for the 8-set direct-mapped icache;
// sole writer of the tag, valid and data arrays.
module icache_fill_ctrl
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic [31:0]       mem_address,
  output logic              mem_resp,
  output logic [31:0]       mem_rdata,
  output logic              pmem_read,
  output logic [31:0]       pmem_address,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [IDX_W-1:0]  arr_rindex,
  output logic [IDX_W-1:0]  arr_windex,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic              valid_in,
  input  logic [LINE_W-1:0] line_in,
  output logic              arr_load,
  output logic [TAG_W-1:0]  tag_out,
  output logic              valid_out,
  output logic [LINE_W-1:0] line_out
);

  fill_state_t       r_state;
  fill_state_t       w_next;
  logic [31:0]       r_req_addr;
  logic              w_hit;
  logic              w_beat_vld;
  logic              w_last;
  logic [LINE_W-1:0] w_line;
  logic [7:0]        w_bit_off;
  logic              w_unused_lsb;

  assign w_hit      = valid_in && (tag_in == addr_tag(r_req_addr));
  assign w_beat_vld = (r_state == FILL) && pmem_resp;
  assign w_bit_off  = {addr_word(r_req_addr), 5'b0};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (mem_read) w_next = TAG;
      TAG:     w_next = w_hit ? IDLE : FILL;
      FILL:    if (w_beat_vld && w_last) w_next = WRITE;
      WRITE:   w_next = TAG;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_req_addr <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && mem_read) r_req_addr <= mem_address;
    end
  end

  // Reset also clears the buffer so an abandoned burst restarts at beat 0.
  icache_line_buf u_line_buf (
    .clk        (clk),
    .i_clear    (rst),
    .i_beat_vld (w_beat_vld),
    .i_data     (pmem_rdata),
    .o_line     (w_line),
    .o_last     (w_last)
  );

  assign mem_resp     = (r_state == TAG) && w_hit;
  assign mem_rdata    = mem_resp ? line_in[w_bit_off +: 32] : '0;

  assign pmem_read    = (r_state == FILL);
  assign pmem_address = pmem_read ? {r_req_addr[31:5], 5'b0} : '0;

  assign arr_rindex   = addr_idx(r_req_addr);
  assign arr_windex   = addr_idx(r_req_addr);
  assign arr_load     = (r_state == WRITE);
  assign tag_out      = arr_load ? addr_tag(r_req_addr) : '0;
  assign valid_out    = 1'b1;
  assign line_out     = arr_load ? w_line : '0;

  assign w_unused_lsb = ^r_req_addr[1:0];

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl: behavioural arrays with write bypass
// and a burst memory with per-beat delays.
module tb_icache_fill_ctrl;

  logic         clk;
  logic         rst;
  logic         mem_read;
  logic [31:0]  mem_address;
  logic         mem_resp;
  logic [31:0]  mem_rdata;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_rdata;
  logic         pmem_resp;
  logic [2:0]   arr_rindex;
  logic [2:0]   arr_windex;
  logic [23:0]  tag_in;
  logic         valid_in;
  logic [255:0] line_in;
  logic         arr_load;
  logic [23:0]  tag_out;
  logic         valid_out;
  logic [255:0] line_out;

  icache_fill_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_resp     (mem_resp),
    .mem_rdata    (mem_rdata),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .arr_rindex   (arr_rindex),
    .arr_windex   (arr_windex),
    .tag_in       (tag_in),
    .valid_in     (valid_in),
    .line_in      (line_in),
    .arr_load     (arr_load),
    .tag_out      (tag_out),
    .valid_out    (valid_out),
    .line_out     (line_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tg, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tg, act, exp);
    end
  endtask

  // Arrays: combinational read, same-cycle bypass of a write to the read index.
  logic [23:0]  t_arr [8];
  logic         v_arr [8];
  logic [255:0] d_arr [8];
  logic         w_byp;
  assign w_byp    = arr_load && (arr_windex == arr_rindex);
  assign tag_in   = w_byp ? tag_out   : t_arr[arr_rindex];
  assign valid_in = w_byp ? valid_out : v_arr[arr_rindex];
  assign line_in  = w_byp ? line_out  : d_arr[arr_rindex];

  int           cyc = 0;
  int           n_load = 0;
  logic [2:0]   cap_windex;
  logic [23:0]  cap_tag;
  logic [255:0] cap_line;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (arr_load) begin
      t_arr[arr_windex] <= tag_out;
      v_arr[arr_windex] <= valid_out;
      d_arr[arr_windex] <= line_out;
      cap_windex        <= arr_windex;
      cap_tag           <= tag_out;
      cap_line          <= line_out;
      n_load            <= n_load + 1;
    end
  end

  // Burst memory: beat b carries nibble (pat_base+b) replicated; dly[b] idle
  // cycles precede beat b.
  int          dly [4];
  int          pat_base = 1;
  bit          stray = 1'b0;
  int          mb, mw;
  bit          bursting = 1'b0;
  int          beats_seen = 0;
  int          last_beat_cyc = 0;
  int          n_pread = 0;
  int          n_resp = 0;
  int          addr_bad = 0;
  logic [31:0] cap_paddr;
  logic [3:0]  nib;

  always @(negedge clk) begin
    pmem_resp = 1'b0;
    if (mem_resp)  n_resp++;
    if (pmem_read) n_pread++;
    if (rst || !pmem_read) begin
      mb = 0;
      mw = dly[0];
      bursting = 1'b0;
      if (stray && !rst) begin
        pmem_resp  = 1'b1;
        pmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      end
    end else begin
      if (!bursting) begin
        bursting  = 1'b1;
        cap_paddr = pmem_address;
      end else if (pmem_address != cap_paddr) addr_bad++;
      if (mw > 0) mw--;
      else if (mb < 4) begin
        nib        = 4'(pat_base + mb);
        pmem_resp  = 1'b1;
        pmem_rdata = {16{nib}};
        mb++;
        beats_seen++;
        last_beat_cyc = cyc;
        if (mb < 4) mw = dly[mb];
      end
    end
  end

  function automatic logic [255:0] exp_line(input int base);
    logic [3:0]   nb;
    logic [255:0] l;
    l = '0;
    for (int b = 0; b < 4; b++) begin
      nb = 4'(base + b);
      l[b*64 +: 64] = {16{nb}};
    end
    return l;
  endfunction

  task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
  endtask

  // Issue one request and hold it until mem_resp; lat counts cycles from the
  // sampling edge's cycle to the response cycle.
  task automatic do_read(input logic [31:0] a, input int base,
                         output logic [31:0] d, output int lat, output int rcyc);
    int st;
    bit got;
    pat_base = base;
    got = 1'b0; d = '0; lat = -1; rcyc = -1;
    @(negedge clk);
    mem_read = 1'b1; mem_address = a; st = cyc;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk); #1;
      if (mem_resp) begin
        got = 1'b1; d = mem_rdata; lat = cyc - st; rcyc = cyc;
      end
    end
    mem_read = 1'b0;
    chk("resp_seen", 256'(got), 256'd1);
  endtask

  logic [31:0] d;
  int lat, rcyc, p0, l0, r0, b0;
  bit seen;

  initial begin
    for (int i = 0; i < 8; i++) begin
      t_arr[i] = '0; v_arr[i] = 1'b0; d_arr[i] = '0;
    end
    rst = 1'b1; mem_read = 1'b0; mem_address = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    set_dly(0, 0, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_resp",  256'(mem_resp),     256'd0);
    chk("rst_pmem_read", 256'(pmem_read),    256'd0);
    chk("rst_arr_load",  256'(arr_load),     256'd0);
    chk("rst_mem_rdata", 256'(mem_rdata),    256'd0);
    chk("rst_paddr",     256'(pmem_address), 256'd0);
    chk("rst_tag_out",   256'(tag_out),      256'd0);
    chk("rst_line_out",  line_out,           256'd0);
    rst = 1'b0;

    // Cold miss to set 2, word 1.
    do_read(32'h0000_0044, 1, d, lat, rcyc);
    chk("cold_rdata",  256'(d),             256'h1111_1111);
    chk("cold_lat",    256'(lat),           256'd7);
    chk("cold_resp_after_last", 256'(rcyc - last_beat_cyc), 256'd2);
    chk("cold_paddr",  256'(cap_paddr),     256'h0000_0040);
    chk("cold_windex", 256'(cap_windex),    256'd2);
    chk("cold_tag",    256'(cap_tag),       256'h0);
    chk("cold_line",   cap_line,            exp_line(1));
    chk("cold_loads",  256'(n_load),        256'd1);

    // Hit on the same line, word 6 = low half of beat 3.
    p0 = n_pread;
    do_read(32'h0000_0058, 1, d, lat, rcyc);
    chk("hit_rdata", 256'(d),             256'h4444_4444);
    chk("hit_lat",   256'(lat),           256'd1);
    chk("hit_no_pmem", 256'(n_pread - p0), 256'd0);

    // Conflict in set 2, then the original line misses again.
    do_read(32'h0000_0140, 5, d, lat, rcyc);
    chk("conf_rdata",  256'(d),          256'h5555_5555);
    chk("conf_paddr",  256'(cap_paddr),  256'h0000_0140);
    chk("conf_windex", 256'(cap_windex), 256'd2);
    chk("conf_tag",    256'(cap_tag),    256'h1);
    p0 = n_pread;
    do_read(32'h0000_0040, 9, d, lat, rcyc);
    chk("remiss_fill",  256'(n_pread > p0), 256'd1);
    chk("remiss_rdata", 256'(d),            256'h9999_9999);
    chk("remiss_lat",   256'(lat),          256'd7);

    // Stray beats while idle, then a burst with 0/3/1/5 idle gaps.
    stray = 1'b1;
    repeat (3) @(negedge clk);
    stray = 1'b0;
    set_dly(0, 3, 1, 5);
    do_read(32'h0000_0064, 2, d, lat, rcyc);
    chk("gap_rdata",  256'(d),          256'h2222_2222);
    chk("gap_lat",    256'(lat),        256'd16);
    chk("gap_resp_after_last", 256'(rcyc - last_beat_cyc), 256'd2);
    chk("gap_windex", 256'(cap_windex), 256'd3);
    chk("gap_line",   cap_line,         exp_line(2));

    // Reset after two beats abandons the fill.
    set_dly(0, 0, 5, 5);
    pat_base = 3; b0 = beats_seen; l0 = n_load; seen = 1'b0;
    @(negedge clk);
    mem_read = 1'b1; mem_address = 32'h0000_0080;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk); #1;
      if (beats_seen - b0 >= 2) seen = 1'b1;
    end
    chk("rstfill_two_beats", 256'(seen), 256'd1);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rstfill_pmem_read", 256'(pmem_read), 256'd0);
    chk("rstfill_arr_load",  256'(arr_load),  256'd0);
    chk("rstfill_mem_resp",  256'(mem_resp),  256'd0);
    rst = 1'b0; mem_read = 1'b0;
    repeat (10) @(negedge clk);
    chk("rstfill_no_write", 256'(n_load - l0), 256'd0);
    set_dly(0, 0, 0, 0);
    b0 = beats_seen;
    do_read(32'h0000_0080, 6, d, lat, rcyc);
    chk("rstfill_rdata",  256'(d),              256'h6666_6666);
    chk("rstfill_lat",    256'(lat),            256'd7);
    chk("rstfill_beats",  256'(beats_seen - b0), 256'd4);
    chk("rstfill_line",   cap_line,             exp_line(6));
    chk("rstfill_windex", 256'(cap_windex),     256'd4);

    // Requester drops mem_read mid-fill.
    pat_base = 4; r0 = n_resp; l0 = n_load; seen = 1'b0;
    @(negedge clk);
    mem_read = 1'b1; mem_address = 32'h0000_00A4;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk); #1;
      if (pmem_read) seen = 1'b1;
    end
    chk("drop_fill_start", 256'(seen), 256'd1);
    mem_read = 1'b0;
    repeat (20) @(negedge clk);
    chk("drop_resp_once", 256'(n_resp - r0), 256'd1);
    chk("drop_written",   256'(n_load - l0), 256'd1);
    chk("drop_windex",    256'(cap_windex),  256'd5);
    chk("drop_line",      cap_line,          exp_line(4));
    do_read(32'h0000_00A8, 4, d, lat, rcyc);
    chk("drop_next_rdata", 256'(d),   256'h5555_5555);
    chk("drop_next_lat",   256'(lat), 256'd1);

    chk("paddr_stable", 256'(addr_bad), 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
